// File: rtl/seg_pkg.sv
`default_nettype none
//==============================================================================
// Package : seg_pkg
// Desc    : Shared constants for the seven-segment scan controller: digit
//           count, select-off pattern, segment bit positions, hex glyph
//           table and the scan state encoding.
// Rev     : 1.0 - initial release
//==============================================================================
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // All digit selects inactive (selects are active-low)
    localparam logic [NUM_DIGITS-1:0] DS_OFF = 8'hFF;

    // Segment bit positions inside a 7-bit code ordered {g,f,e,d,c,b,a}
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Hex value -> segment code, index 0 first
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface : seg_scan_if
// Desc      : Buffer write port, display control inputs and display pins of
//             the seven-segment scan controller.
// Rev       : 1.0 - initial release
//==============================================================================
interface seg_scan_if;

    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] dig_en;
    logic       lz_blank;

    logic [7:0] ds;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       e;
    logic       f;
    logic       g;
    logic       dp;
    logic [2:0] scan_idx;
    logic       frame_tick;

    // Upstream logic driving the buffer and controls
    modport master (
        output wr_en, wr_addr, wr_data, dig_en, lz_blank,
        input  ds, a, b, c, d, e, f, g, dp, scan_idx, frame_tick
    );

    // The scan controller itself
    modport slave (
        input  wr_en, wr_addr, wr_data, dig_en, lz_blank,
        output ds, a, b, c, d, e, f, g, dp, scan_idx, frame_tick
    );

endinterface : seg_scan_if
`default_nettype wire

// File: rtl/seg_hex_dec.sv
`default_nettype none
//==============================================================================
// Module : seg_hex_dec
// Desc   : Combinational 4-bit hex value to 7-segment code {g,f,e,d,c,b,a}.
// Rev    : 1.0 - initial release
//==============================================================================
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Straight table lookup; every 4-bit value has a glyph
    assign seg = HEX_SEG_TABLE[value];

endmodule : seg_hex_dec
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
//==============================================================================
// Module : seg_scan_ctrl
// Desc   : Time-multiplexed scan controller for an 8-digit common-select
//          seven-segment display. Holds an 8-entry digit buffer, steps
//          through the digits with a blanking gap at the start of each slot,
//          and applies a per-digit enable mask and leading-zero suppression.
//          All pin outputs are registered.
// Rev    : 1.0 - initial release
//==============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int unsigned           c_cnt_w      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last   = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_blank_last = c_cnt_w'(BLANK_CYC - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one    = c_cnt_w'(1);

    logic [4:0]         r_buf [NUM_DIGITS];
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic               r_started;
    logic               r_tick;
    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [7:0]         r_ds;
    logic [7:0]         w_ds_nxt;
    logic [6:0]         r_seg;
    logic [6:0]         w_seg_nxt;
    logic               r_dp;
    logic               w_dp_nxt;

    logic               w_wrap;
    logic               w_show_entry;
    logic               w_upper_zero;
    logic               w_suppress;
    logic               w_visible;
    logic [6:0]         w_dec_seg;

    // Slot boundaries; nothing moves until the scan has been armed
    assign w_wrap       = r_started && (r_cnt == c_cnt_last);
    assign w_show_entry = r_started && (r_cnt == c_blank_last);

    // Digit buffer: one write per cycle, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_buf[k] <= 5'h00;
            end
        end else if (bus.wr_en) begin
            r_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Slot counter, digit index and frame pulse. The first edge after reset
    // release only arms the scan so that frame_tick is seen together with
    // cnt = 0 / scan_idx = 0 on the very first running cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_started <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= !r_started || (w_wrap && (r_idx == 3'd7));
            if (!r_started) begin
                r_started <= 1'b1;
            end else if (w_wrap) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // True when every entry from the current digit up to digit 7 is blank
    always_comb begin
        w_upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(r_idx)) && (r_buf[j] != 5'h00)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_suppress = bus.lz_blank && (r_idx != 3'd0) && w_upper_zero;
    assign w_visible  = bus.dig_en[r_idx] && !w_suppress;

    seg_hex_dec u_hex_dec (
        .value (r_buf[r_idx][3:0]),
        .seg   (w_dec_seg)
    );

    // State and pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_ds    <= DS_OFF;
            r_seg   <= 7'd0;
            r_dp    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ds    <= w_ds_nxt;
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
        end
    end

    // Next state and next pin values; the digit's code, dp and visibility
    // are captured once at SHOW entry and held for the rest of the slot
    always_comb begin
        w_state_nxt = r_state;
        w_ds_nxt    = r_ds;
        w_seg_nxt   = r_seg;
        w_dp_nxt    = r_dp;
        case (r_state)
            ST_BLANK: begin
                if (w_show_entry) begin
                    w_state_nxt = ST_SHOW;
                    if (w_visible) begin
                        w_ds_nxt  = DS_OFF & ~(8'b1 << r_idx);
                        w_seg_nxt = w_dec_seg;
                        w_dp_nxt  = r_buf[r_idx][4];
                    end
                end
            end
            ST_SHOW: begin
                if (w_wrap) begin
                    w_state_nxt = ST_BLANK;
                    w_ds_nxt    = DS_OFF;
                    w_seg_nxt   = 7'd0;
                    w_dp_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_ds_nxt    = DS_OFF;
                w_seg_nxt   = 7'd0;
                w_dp_nxt    = 1'b0;
            end
        endcase
    end

    assign bus.ds         = r_ds;
    assign bus.a          = r_seg[SEG_A];
    assign bus.b          = r_seg[SEG_B];
    assign bus.c          = r_seg[SEG_C];
    assign bus.d          = r_seg[SEG_D];
    assign bus.e          = r_seg[SEG_E];
    assign bus.f          = r_seg[SEG_F];
    assign bus.g          = r_seg[SEG_G];
    assign bus.dp         = r_dp;
    assign bus.scan_idx   = r_idx;
    assign bus.frame_tick = r_tick;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit common-select seven-segment display.
- Holds an 8-entry digit buffer that is written by a simple write port.
- Sequences the digits one at a time, with a blanking gap between digits to prevent ghosting, and applies a per-digit enable mask and optional leading-zero suppression.
- Sits between counter/marquee logic and the board display pins. It replaces ad-hoc per-design scan logic.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (blank + show); must be > BLANK_CYC.
- BLANK_CYC, 500: cycles at the start of each slot with all selects off; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write strobe; one write per cycle
- wr_addr  in  3  digit index; 0 = rightmost
- wr_data  in  5  bit4 = dp, bits3:0 = hex value
- dig_en  in  8  per-digit enable mask; 0 keeps that digit dark
- lz_blank  in  1  leading-zero suppression enable
- ds  out  8  digit selects, active-low; digit k drives ds[k]
- a,b,c,d,e,f,g  out  1 each  segments, active-high
- dp  out  1  decimal point, active-high
- scan_idx  out  3  digit currently owning the slot
- frame_tick  out  1  one-cycle pulse at the start of each frame (slot of digit 0)

Behaviour:
- Reset (async):
  - buffer entries = 5'h00
  - ds = 8'hFF
  - a..g and dp = 0
  - scan_idx = 0, slot counter cnt = 0, state = BLANK, frame_tick = 0
- Slot counter:
  - cnt runs 0..SCAN_DIV-1, then wraps to 0.
  - On each wrap, scan_idx increments modulo 8.
  - frame_tick = 1 for exactly the cycle in which cnt = 0 and scan_idx = 0, including the first cycle after reset release.
- State machine (2 states):
  - BLANK (cnt < BLANK_CYC): ds = 8'hFF; segments and dp = 0.
  - BLANK -> SHOW on the edge where cnt goes BLANK_CYC-1 -> BLANK_CYC. At that edge the controller latches the decoded segments of entry scan_idx, the dp bit, and the suppress decision.
  - SHOW (cnt ≥ BLANK_CYC): if the digit is visible, ds[scan_idx] = 0 and all other ds bits = 1; segments = latched code. If the digit is not visible, outputs stay as in BLANK.
  - SHOW -> BLANK on the cnt wrap.
- Visibility: visible = dig_en[scan_idx] AND NOT suppress. Both are sampled at SHOW entry.
- Disabled digits still consume their slot, so the refresh rate is constant regardless of the mask.
- Leading-zero suppression: suppress = lz_blank AND scan_idx ≠ 0 AND every entry j with scan_idx ≤ j ≤ 7 has value 0 and dp 0. Digit 0 is never suppressed.
- Hex decode, with segment bit order {g,f,e,d,c,b,a}:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111
  - 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111
  - 8 = 1111111, 9 = 1101111, A = 1110111, b = 1111100
  - C = 0111001, d = 1011110, E = 1111001, F = 1110001
- Writes:
  - The buffer updates on the clock edge where wr_en = 1; the new value is readable next cycle.
  - A write to the digit currently in SHOW does not change the outputs until that digit's next slot (values are latched, so there is no mid-slot glitch).
- Simultaneous events:
  - A write on the same edge as SHOW entry for the same address: the latch captures the OLD value.
  - dig_en and lz_blank changes mid-slot have no effect until the next SHOW entry.
- Reset mid-operation: outputs go dark immediately (async) and the buffer clears. The scan restarts at digit 0 in BLANK.
- All outputs are registered; no combinational path from inputs to pins.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry hex-to-segment constant table
  - segment bit positions
  - digit count (8)
  - constant DS_OFF = 8'hFF
- One sub-module, seg_hex_dec: combinational 4-bit value -> 7-bit segment code, built from the package table.
- The counter, FSM, buffer and suppression logic stay in seg_scan_ctrl.

Test Plan (SCAN_DIV = 8, BLANK_CYC = 2 unless stated):
- Reset, no writes, dig_en = 8'hFF, lz_blank = 0 -> ds = 8'hFF for cnt 0–1; ds = 8'hFE with segs 0111111 for cnt 2–7. frame_tick high at cycle 0 and again at cycle 64.
- Write addr 3 = 5'h1A -> in slot 3 SHOW: ds = 8'hF7, segs = 1110111, dp = 1. The other digits show "0".
- lz_blank = 1, buffer = {0,0,0,0,0,0,4,2} (digit 7..0) -> digits 7–2 dark (ds = 8'hFF); digit 1 shows "4"; digit 0 shows "2". Then buffer all zero -> only digit 0 lit, showing "0".
- dig_en = 8'b0000_0101 -> only slots 0 and 2 drive ds low; slots 1 and 3–7 stay 8'hFF; frame period still 64 cycles.
- Write addr 0 = 5'h09 at cnt = 4 while digit 0 is in SHOW -> segs stay "0" through cnt 7; "9" (1101111) appears at digit 0's next SHOW. Write on the SHOW-entry edge -> old value captured.
- Assert rst at cnt = 5 of slot 6 -> ds = 8'hFF and segments 0 immediately; buffer reads 0. After release, scan_idx = 0 and frame_tick pulses on the first cycle.
